// File: rtl/fft_r22sdf_pkg.sv
// Shared helpers for the radix-2^2 SDF FFT sequencer: width math, bin-index
// bit reversal, per-stage pipeline delay and the twiddle quadrant multiplier.
package fft_r22sdf_pkg;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) r[i] = v[width-1-i];
      end
      return r;
   endfunction

   // Samples take this many accepted cycles to reach stage s: each earlier
   // stage pair adds its BFI/BFII feedback delays plus one multiplier.
   function automatic int stage_delay(input int s, input int log2n, input int mult_lat);
      int acc;
      acc = 0;
      for (int j = 0; j < s; j++) begin
         acc += 3 * ((1 << log2n) >> (2 * j + 2)) + mult_lat;
      end
      return acc;
   endfunction

   function automatic logic [1:0] tw_mult(input logic [1:0] q);
      logic [1:0] m;
      case (q)
         2'd0:    m = 2'd0;
         2'd1:    m = 2'd2;
         2'd2:    m = 2'd1;
         default: m = 2'd3;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/fft_r22sdf_ctrl_if.sv
// Control bundle between the FFT sequencer (slave) and whoever drives the
// sample stream and consumes the per-stage selects (master).
interface fft_r22sdf_ctrl_if #(
   parameter int LOG2N   = 10,
   parameter int NSTAGES = LOG2N / 2
);
   logic                             in_valid_i;
   logic                             sync_clr_i;
   logic                             ce_o;
   logic [NSTAGES-1:0]               bfi_sel_o;
   logic [NSTAGES-1:0]               bfii_sel_o;
   logic [NSTAGES-1:0]               bfii_tsel_o;
   logic [(NSTAGES-1)*LOG2N-1:0]     tw_addr_o;
   logic                             out_valid_o;
   logic                             out_last_o;
   logic [LOG2N-1:0]                 out_idx_o;

   modport slave (
      input  in_valid_i, sync_clr_i,
      output ce_o, bfi_sel_o, bfii_sel_o, bfii_tsel_o, tw_addr_o,
             out_valid_o, out_last_o, out_idx_o
   );

   modport master (
      output in_valid_i, sync_clr_i,
      input  ce_o, bfi_sel_o, bfii_sel_o, bfii_tsel_o, tw_addr_o,
             out_valid_o, out_last_o, out_idx_o
   );
endinterface

// File: rtl/fft_r22sdf_tw_addr.sv
// Twiddle ROM address for one multiplier stage, registered so it lines up
// with the sample the multiplier sees at the same clock-enable edge.
module fft_r22sdf_tw_addr
   import fft_r22sdf_pkg::*;
#(
   parameter int LOG2N = 10,
   parameter int STAGE = 0,
   localparam int W    = LOG2N - 2 * STAGE
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             ld_i,
   input  logic [W-1:0]     c_i,
   output logic [LOG2N-1:0] addr_o
);
   localparam int N   = 1 << LOG2N;
   localparam int OFF = 3 * (N >> (2 * STAGE + 2));

   logic [W-1:0]     d;
   logic [1:0]       m;
   logic [LOG2N-1:0] prod;
   logic [LOG2N-1:0] addr_d;
   logic [LOG2N-1:0] addr_q;

   // Twiddles only apply once the BFII output window starts, hence the
   // offset by three quarters of this stage's span.
   assign d = c_i - W'(OFF);

   always_comb begin
      m      = tw_mult(d[W-1:W-2]);
      prod   = LOG2N'(m) * LOG2N'(d[W-3:0]);
      addr_d = addr_q;
      if (ld_i) addr_d = prod << (2 * STAGE);
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) addr_q <= '0;
      else        addr_q <= addr_d;
   end

   assign addr_o = addr_q;
endmodule

// File: rtl/fft_r22sdf_ctrl.sv
// Sequencer for a streaming radix-2^2 SDF FFT: sample counting, per-stage
// butterfly selects, twiddle addresses, priming and bit-reversed output index.
module fft_r22sdf_ctrl
   import fft_r22sdf_pkg::*;
#(
   parameter int LOG2N    = 10,
   parameter int MULT_LAT = 1,
   localparam int NSTAGES = LOG2N / 2
) (
   input logic              clk_i,
   input logic              rst_n,
   fft_r22sdf_ctrl_if.slave bus
);
   localparam int N  = 1 << LOG2N;
   localparam int L  = (N - 1) + (NSTAGES - 1) * MULT_LAT;
   localparam int PW = clog2(L + 1);

   logic                         ld;
   logic [LOG2N-1:0]             cnt_d, cnt_q;
   logic [PW-1:0]                pcnt_d, pcnt_q;
   logic                         primed_d, primed_q;
   logic [LOG2N-1:0]             ocnt_d, ocnt_q;
   logic                         out_valid_d, out_valid_q;
   logic                         out_last_d, out_last_q;
   logic [LOG2N-1:0]             out_idx_d, out_idx_q;
   logic [NSTAGES-1:0]           bfi_nxt, bfii_nxt, tsel_nxt;
   logic [NSTAGES-1:0]           bfi_d, bfi_q, bfii_d, bfii_q, tsel_d, tsel_q;
   logic [(NSTAGES-1)*LOG2N-1:0] tw_addr;

   // A sync clear also reloads the selects so they realign to count zero.
   assign ld = bus.in_valid_i | bus.sync_clr_i;

   always_comb begin
      cnt_d       = cnt_q;
      pcnt_d      = pcnt_q;
      primed_d    = primed_q;
      ocnt_d      = ocnt_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_idx_d   = out_idx_q;
      if (bus.sync_clr_i) begin
         cnt_d     = '0;
         pcnt_d    = '0;
         primed_d  = 1'b0;
         ocnt_d    = '0;
         out_idx_d = '0;
      end else if (bus.in_valid_i) begin
         cnt_d = cnt_q + LOG2N'(1);
         if (!primed_q) begin
            pcnt_d   = pcnt_q + PW'(1);
            primed_d = (pcnt_q == PW'(L - 1));
         end else begin
            out_valid_d = 1'b1;
            out_last_d  = (ocnt_q == {LOG2N{1'b1}});
            out_idx_d   = LOG2N'(bitrev(32'(ocnt_q), LOG2N));
            ocnt_d      = ocnt_q + LOG2N'(1);
         end
      end
   end

   // Selects are computed from the next count so the registered value
   // matches the sample presented to each stage after the edge.
   for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
      localparam int W  = LOG2N - 2 * s;
      localparam int SD = stage_delay(s, LOG2N, MULT_LAT) % N;

      logic [W-1:0] c_loc;

      assign c_loc       = W'(cnt_d - LOG2N'(SD));
      assign bfi_nxt[s]  = c_loc[W-1];
      assign bfii_nxt[s] = c_loc[W-2];
      assign tsel_nxt[s] = ~c_loc[W-1];

      if (s < NSTAGES - 1) begin : g_tw
         fft_r22sdf_tw_addr #(
            .LOG2N (LOG2N),
            .STAGE (s)
         ) u_tw (
            .clk_i  (clk_i),
            .rst_n  (rst_n),
            .ld_i   (ld),
            .c_i    (c_loc),
            .addr_o (tw_addr[s*LOG2N +: LOG2N])
         );
      end
   end

   always_comb begin
      bfi_d  = bfi_q;
      bfii_d = bfii_q;
      tsel_d = tsel_q;
      if (ld) begin
         bfi_d  = bfi_nxt;
         bfii_d = bfii_nxt;
         tsel_d = tsel_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         pcnt_q      <= '0;
         primed_q    <= 1'b0;
         ocnt_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_idx_q   <= '0;
         bfi_q       <= '0;
         bfii_q      <= '0;
         tsel_q      <= '0;
      end else begin
         cnt_q       <= cnt_d;
         pcnt_q      <= pcnt_d;
         primed_q    <= primed_d;
         ocnt_q      <= ocnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_idx_q   <= out_idx_d;
         bfi_q       <= bfi_d;
         bfii_q      <= bfii_d;
         tsel_q      <= tsel_d;
      end
   end

   assign bus.ce_o        = bus.in_valid_i;
   assign bus.bfi_sel_o   = bfi_q;
   assign bus.bfii_sel_o  = bfii_q;
   assign bus.bfii_tsel_o = tsel_q;
   assign bus.tw_addr_o   = tw_addr;
   assign bus.out_valid_o = out_valid_q;
   assign bus.out_last_o  = out_last_q;
   assign bus.out_idx_o   = out_idx_q;
endmodule
